// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures instructions into IR, applies decode redirects.
// Optional performance counters enabled with `define FETCH_PERF_CNT_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Branch,
  input  logic [15:0] BrImm,
  input  logic        Jump,
  input  logic [25:0] JTarget,
  input  logic        Halt,
  input  logic [31:0] Inst,
  output logic [31:0] Addr,
  output logic [31:0] IR,
  output logic [31:0] IRPC4,
  output logic        IRValid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] FetchCnt,
  output logic [31:0] StallCnt,
`endif
  output logic        Halted
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] irpc4_q, irpc4_d;
  logic        irvalid_q, irvalid_d;
  logic [31:0] br_off;
  logic [31:0] pc_plus4;

  assign br_off   = {{14{BrImm[15]}}, BrImm, 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_INST;
      irpc4_q   <= '0;
      irvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      irpc4_q   <= irpc4_d;
      irvalid_q <= irvalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    irpc4_d   = irpc4_q;
    irvalid_d = irvalid_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (Stall) begin
          state_d = ST_RUN;
        end else if (Halt && irvalid_q) begin
          state_d   = ST_HALTED;
          ir_d      = NOP_INST;
          irvalid_d = 1'b0;
        end else if (Jump && irvalid_q) begin
          pc_d      = {irpc4_q[31:28], JTarget, 2'b00};
          ir_d      = NOP_INST;
          irvalid_d = 1'b0;
        end else if (Branch && irvalid_q) begin
          pc_d      = irpc4_q + br_off;
          ir_d      = NOP_INST;
          irvalid_d = 1'b0;
        end else begin
          ir_d      = Inst;
          irpc4_d   = pc_plus4;
          irvalid_d = 1'b1;
          pc_d      = pc_plus4;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_BOOT;
    endcase
  end

  assign Addr    = pc_q;
  assign IR      = ir_q;
  assign IRPC4   = irpc4_q;
  assign IRValid = irvalid_q;
  assign Halted  = (state_q == ST_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        run_fetch, run_stall;

  assign run_stall = (state_q == ST_RUN) && Stall;
  assign run_fetch = (state_q == ST_RUN) && !Stall &&
                     !(irvalid_q && (Halt || Jump || Branch));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (run_fetch) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (run_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign FetchCnt = fetch_cnt_q;
  assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed test-plan sequences followed by randomized decode traffic.
module tb_pc_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Stall, Branch, Jump, Halt;
  logic [15:0] BrImm;
  logic [25:0] JTarget;
  logic [31:0] Inst, Addr, IR, IRPC4;
  logic        IRValid, Halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCnt, StallCnt;
`endif

  always #5 Clk = ~Clk;

  logic [31:0] rom [256];
  assign Inst = rom[Addr[9:2]];

  pc_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0000)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Stall   (Stall),
    .Branch  (Branch),
    .BrImm   (BrImm),
    .Jump    (Jump),
    .JTarget (JTarget),
    .Halt    (Halt),
    .Inst    (Inst),
    .Addr    (Addr),
    .IR      (IR),
    .IRPC4   (IRPC4),
    .IRValid (IRValid),
`ifdef FETCH_PERF_CNT_EN
    .FetchCnt(FetchCnt),
    .StallCnt(StallCnt),
`endif
    .Halted  (Halted)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ir;
    logic [31:0] irpc4;
    logic        valid;
    logic        halted;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: architectural view of the fetch stage
  logic [31:0] m_pc, m_ir, m_irpc4, m_fcnt, m_scnt;
  logic        m_valid, m_booted, m_halted;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic void model_reset();
    m_pc = 32'h0; m_ir = 32'h0; m_irpc4 = 32'h0; m_valid = 1'b0;
    m_booted = 1'b0; m_halted = 1'b0; m_fcnt = 32'h0; m_scnt = 32'h0;
  endfunction

  function automatic void model_edge(logic s, logic b, logic [15:0] imm, logic j,
                                     logic [25:0] jt, logic h);
    logic [31:0] off;
    off = 32'($signed(imm)) * 32'd4;
    if (!m_booted) m_booted = 1'b1;
    else if (m_halted) begin end
    else if (s) m_scnt = m_scnt + 1;
    else if (h && m_valid) begin
      m_halted = 1'b1; m_valid = 1'b0; m_ir = 32'h0;
    end else if (j && m_valid) begin
      m_pc = {m_irpc4[31:28], jt, 2'b00}; m_valid = 1'b0; m_ir = 32'h0;
    end else if (b && m_valid) begin
      m_pc = m_irpc4 + off; m_valid = 1'b0; m_ir = 32'h0;
    end else begin
      m_ir = rom[m_pc[9:2]]; m_irpc4 = m_pc + 4; m_valid = 1'b1;
      m_pc = m_pc + 4; m_fcnt = m_fcnt + 1;
    end
  endfunction

  // Called at a negedge: drive, predict the post-edge state, return at the next negedge
  task automatic step(input logic s, input logic b, input logic [15:0] imm,
                      input logic j, input logic [25:0] jt, input logic h);
    exp_t e;
    Stall = s; Branch = b; BrImm = imm; Jump = j; JTarget = jt; Halt = h;
    model_edge(s, b, imm, j, jt, h);
    e.addr = m_pc; e.ir = m_ir; e.irpc4 = m_irpc4; e.valid = m_valid;
    e.halted = m_halted; e.fcnt = m_fcnt; e.scnt = m_scnt;
    q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0);
  endtask

  task automatic rand_step();
    step(($urandom % 5) == 0, ($urandom % 6) == 0, 16'($urandom),
         ($urandom % 8) == 0, 26'($urandom), ($urandom % 40) == 0);
  endtask

  // Asserted mid-cycle at a negedge; reset values must appear without a clock edge
  task automatic do_reset();
    Stall = 0; Branch = 0; Jump = 0; Halt = 0; BrImm = '0; JTarget = '0;
    Rst_n = 1'b0;
    #1;
    chk("rst_addr", Addr, 32'h0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_irpc4", IRPC4, 32'h0);
    chk("rst_irvalid", 32'(IRValid), 32'h0);
    chk("rst_halted", 32'(Halted), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetchcnt", FetchCnt, 32'h0);
    chk("rst_stallcnt", StallCnt, 32'h0);
`endif
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_addr", Addr, e.addr);
        chk("sb_ir", IR, e.ir);
        chk("sb_irpc4", IRPC4, e.irpc4);
        chk("sb_irvalid", 32'(IRValid), 32'(e.valid));
        chk("sb_halted", 32'(Halted), 32'(e.halted));
`ifdef FETCH_PERF_CNT_EN
        chk("sb_fetchcnt", FetchCnt, e.fcnt);
        chk("sb_stallcnt", StallCnt, e.scnt);
`endif
      end
    end
  end

  initial begin : stimulus
    Rst_n = 1'b0;
    Stall = 0; Branch = 0; Jump = 0; Halt = 0; BrImm = '0; JTarget = '0;
    for (int unsigned i = 0; i < 256; i++) rom[i] = $urandom;
    rom[6] = 32'h1422_0002;
    model_reset();
    @(negedge Clk);
    do_reset();

    // Boot and sequential fetch
    idle();
    chk("boot_addr", Addr, 32'h0);
    chk("boot_irvalid", 32'(IRValid), 32'h0);
    for (int unsigned i = 0; i < 7; i++) idle();
    chk("seq_irpc4", IRPC4, 32'h1C);
    chk("seq_ir_bne", IR, 32'h1422_0002);

    // Taken bne with offset 2
    step(1'b0, 1'b1, 16'h0002, 1'b0, 26'h0, 1'b0);
    chk("br_addr", Addr, 32'h24);
    chk("br_flush_valid", 32'(IRValid), 32'h0);
    chk("br_flush_ir", IR, 32'h0);
    idle();
    chk("br_capture_irpc4", IRPC4, 32'h28);
    chk("br_capture_ir", IR, rom[9]);
    idle();

    // Jump beats Branch
    step(1'b0, 1'b1, 16'h0040, 1'b1, 26'h0D, 1'b0);
    chk("jmp_addr", Addr, 32'h34);
    chk("jmp_flush_valid", 32'(IRValid), 32'h0);
    idle();

    // Land on 0x0C, capture it, then stall at PC=0x10 with Branch asserted
    step(1'b0, 1'b1, 16'hFFF5, 1'b0, 26'h0, 1'b0);
    chk("brneg_addr", Addr, 32'h0C);
    idle();
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 16'h0100, 1'b0, 26'h0, 1'b0);
      chk("stall_addr", Addr, 32'h10);
      chk("stall_irpc4", IRPC4, 32'h10);
      chk("stall_irvalid", 32'(IRValid), 32'h1);
    end
    idle();
    chk("post_stall_irpc4", IRPC4, 32'h14);
    chk("post_stall_ir", IR, rom[4]);

    // Halt with PC=0x4C
    step(1'b0, 1'b1, 16'd13, 1'b0, 26'h0, 1'b0);
    idle();
    chk("pre_halt_addr", Addr, 32'h4C);
    step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1);
    chk("halt_halted", 32'(Halted), 32'h1);
    chk("halt_irvalid", 32'(IRValid), 32'h0);
    for (int unsigned i = 0; i < 10; i++) begin
      rand_step();
      chk("halt_addr_frozen", Addr, 32'h4C);
    end
    do_reset();

    // PC wraps from 0xFFFF_FFFC to 0
    idle();
    idle();
    step(1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0);
    chk("wrap_target", Addr, 32'hFFFF_FFFC);
    idle();
    chk("wrap_addr", Addr, 32'h0);
    chk("wrap_irpc4", IRPC4, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    idle();
    for (int unsigned i = 0; i < 5; i++) idle();
    step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 26'h0123, 1'b0);
    chk("perf_fetchcnt", FetchCnt, 32'd5);
    chk("perf_stallcnt", StallCnt, 32'd2);
`endif

    // Randomized decode traffic, with resets both from HALTED and mid-run
    do_reset();
    for (int unsigned i = 0; i < 3000; i++) begin
      if ((m_halted && ($urandom % 4) == 0) || ($urandom % 300) == 0) do_reset();
      else rand_step();
    end

    @(posedge Clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
